wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the NR_PORTS writeback/bypass ports between NR_REQ functional-unit result sources.
- Sits between the FU result outputs and the execute-to-writeback pipeline register path.
- Each cycle it selects up to NR_PORTS valid requesters by round-robin, acknowledges them with a combinational ready, and drives the selected results onto registered writeback ports one cycle later.
- Lets FUs be added without adding register-file write ports.

Parameters:
- NR_REQ, 4, number of FU result requesters (at least 2).
- NR_PORTS, 2, number of writeback ports (at least 1, at most NR_REQ).
- ID_W, 8, instruction id width.
- PREG_W, 6, physical destination register index width.
- XLEN, 64, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush: no grants this cycle; clears outputs next cycle.
- req_valid_i  in  NR_REQ  requester r holds a result.
- req_ready_o  out  NR_REQ  requester r is granted this cycle; transfer when valid && ready.
- req_id_i  in  NR_REQ x ID_W  instruction id per requester.
- req_pc_i  in  NR_REQ x XLEN  pc per requester.
- req_prd_i  in  NR_REQ x PREG_W  physical destination per requester.
- req_rdval_i  in  NR_REQ x XLEN  result value per requester.
- wb_valid_o  out  NR_PORTS  port k carries a result.
- wb_id_o  out  NR_PORTS x ID_W  id on port k.
- wb_pc_o  out  NR_PORTS x XLEN  pc on port k.
- wb_prd_o  out  NR_PORTS x PREG_W  destination on port k.
- wb_rdval_o  out  NR_PORTS x XLEN  value on port k.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wb_valid_o=0; all wb_* payload outputs=0.
  - rr_ptr=0.
  - req_ready_o=0 combinationally while rst=1.
- Grant selection (combinational, same cycle as request):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NR_REQ.
  - The first NR_PORTS indices with req_valid_i=1 are granted.
  - The j-th granted index in scan order is assigned to port j.
- req_ready_o[r]=1 iff r is granted and rst=0 and flush_i=0. Ready depends only on valid, state, rst and flush_i; there is no combinational path from the wb side.
- Requesters must hold valid and payload stable until ready. The arbiter never drops an asserted request: an ungranted requester simply waits.
- Latency: exactly 1 cycle. A result granted in cycle N appears on wb_* of its assigned port in cycle N+1 with wb_valid_o=1.
- Ports with no grant in cycle N have wb_valid_o=0 in N+1; their payload holds its previous value.
- Writeback side is always ready; there is no backpressure input.
- rr_ptr update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NR_REQ.
  - Otherwise rr_ptr holds.
  - rr_ptr width is clog2(NR_REQ); wrap-around is explicit modulo, with no reliance on power-of-two NR_REQ.
- Fairness: any continuously valid requester is granted within ceil(NR_REQ/NR_PORTS) cycles.
- flush_i=1:
  - No grants; all ready=0.
  - wb_valid_o=0 next cycle.
  - rr_ptr holds.
  - A result already registered (wb_valid_o=1 during the flush cycle) is still presented that cycle; the consumer discards it.
- rst during operation: in-flight registered results are lost; valids clear next edge. Requesters must also be reset.
- Simultaneous rst and flush_i: rst dominates; result is identical to reset.
- NR_PORTS=NR_REQ: every valid requester is granted every cycle.

Optional Feature:
- Macro: WB_PORT_ARBITER_PERF_EN.
- When defined, two extra outputs are present:
  - perf_grants_o, 32-bit: total transfers, incremented by the popcount of grants each cycle.
  - perf_conflicts_o, 32-bit: cycles with popcount(req_valid_i) > NR_PORTS and no flush.
- Both counters wrap modulo 2^32, reset to 0 on rst, and do not count during rst or flush_i.
- When not defined, the ports and counters are absent; arbitration behaviour is identical.

Test Plan (NR_REQ=4, NR_PORTS=2):
- Reset, then req_valid_i=0000 for 3 cycles -> wb_valid_o=00, rr_ptr stays 0, ready=0000.
- req_valid_i=1111 held 4 cycles, rr_ptr=0 -> ready sequence 0011, 1100, 0011, 1100. Port0/port1 ids follow requesters (0,1), (2,3), (0,1), (2,3), each 1 cycle later.
- rr_ptr=3, req_valid_i=1001 (r0 and r3) -> ready=1001; port0 gets r3, port1 gets r0 next cycle; rr_ptr becomes 1.
- Single request r2 with rdval=0xDEADBEEF, prd=5 -> port0 shows valid=1, prd=5, rdval=0xDEADBEEF next cycle; port1 valid=0; rr_ptr=3.
- flush_i=1 with req_valid_i=1111 -> ready=0000, wb_valid_o=00 next cycle, rr_ptr unchanged. rst asserted mid-stream with flush_i=1 -> outputs 0, rr_ptr=0.
- PERF_EN: 10 cycles of req_valid_i=0111 -> perf_grants_o=20, perf_conflicts_o=10. Then 5 cycles of 0001 -> grants=25, conflicts=10.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares NR_PORTS writeback/bypass ports between NR_REQ functional-unit
//   result sources. Each cycle up to NR_PORTS valid requesters are picked
//   by round-robin starting at rr_ptr. They get a combinational ready and
//   their results appear on registered wb_* ports one cycle later.
//
// Handshake: a requester transfers in a cycle when req_valid_i[r] &&
//   req_ready_o[r]. It must hold valid and its payload stable until it
//   sees ready. Ready depends only on req_valid_i, rr_ptr, rst and flush_i.
//   The writeback side is always ready.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush_i         no grants this cycle; wb_valid_o clears next cycle
//   req_valid_i     per-requester valid
//   req_ready_o     per-requester grant (combinational)
//   req_id_i/pc_i/prd_i/rdval_i   per-requester payload
//   wb_valid_o      per-port valid (registered)
//   wb_id_o/pc_o/prd_o/rdval_o    per-port payload (registered)
//   dbg_rr_ptr_o    current round-robin pointer
//   perf_grants_o, perf_conflicts_o
//                   present only when WB_PORT_ARBITER_PERF_EN is defined
module wb_port_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int NR_PORTS = 2,
  parameter int ID_W     = 8,
  parameter int PREG_W   = 6,
  parameter int XLEN     = 64,
  localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [NR_REQ-1:0]                  req_valid_i,
  output logic [NR_REQ-1:0]                  req_ready_o,
  input  logic [NR_REQ-1:0][ID_W-1:0]        req_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]        req_pc_i,
  input  logic [NR_REQ-1:0][PREG_W-1:0]      req_prd_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]        req_rdval_i,
  output logic [NR_PORTS-1:0]                wb_valid_o,
  output logic [NR_PORTS-1:0][ID_W-1:0]      wb_id_o,
  output logic [NR_PORTS-1:0][XLEN-1:0]      wb_pc_o,
  output logic [NR_PORTS-1:0][PREG_W-1:0]    wb_prd_o,
  output logic [NR_PORTS-1:0][XLEN-1:0]      wb_rdval_o,
`ifdef WB_PORT_ARBITER_PERF_EN
  output logic [31:0]                        perf_grants_o,
  output logic [31:0]                        perf_conflicts_o,
`endif
  output logic [PTR_W-1:0]                   dbg_rr_ptr_o
);

  logic [PTR_W-1:0]                  r_rr_ptr;
  logic [NR_PORTS-1:0]               r_wb_valid;
  logic [NR_PORTS-1:0][ID_W-1:0]     r_wb_id;
  logic [NR_PORTS-1:0][XLEN-1:0]     r_wb_pc;
  logic [NR_PORTS-1:0][PREG_W-1:0]   r_wb_prd;
  logic [NR_PORTS-1:0][XLEN-1:0]     r_wb_rdval;

  logic [NR_REQ-1:0]                 w_grant;
  logic [NR_PORTS-1:0]               w_port_v;
  logic [NR_PORTS-1:0][PTR_W-1:0]    w_port_sel;
  logic [PTR_W-1:0]                  w_next_ptr;

  // Scan from rr_ptr with explicit modulo wrap; the n-th valid index found
  // goes to port n. The pointer advances past the last granted index.
  always_comb begin : p_select
    int n;
    int idx;
    w_grant    = '0;
    w_port_v   = '0;
    w_port_sel = '0;
    w_next_ptr = r_rr_ptr;
    n          = 0;
    idx        = 0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (req_valid_i[idx] && (n < NR_PORTS)) begin
        w_grant[idx]  = 1'b1;
        w_port_v[n]   = 1'b1;
        w_port_sel[n] = PTR_W'(idx);
        w_next_ptr    = (idx == NR_REQ - 1) ? '0 : PTR_W'(idx + 1);
        n             = n + 1;
      end
    end
    // Reset and flush suppress every grant and freeze the pointer.
    if (rst || flush_i) begin
      w_grant    = '0;
      w_port_v   = '0;
      w_next_ptr = r_rr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= '0;
      r_wb_id    <= '0;
      r_wb_pc    <= '0;
      r_wb_prd   <= '0;
      r_wb_rdval <= '0;
    end else begin
      r_rr_ptr <= w_next_ptr;
      for (int k = 0; k < NR_PORTS; k++) begin
        r_wb_valid[k] <= w_port_v[k];
        // Ungranted ports keep their old payload; only valid drops.
        if (w_port_v[k]) begin
          r_wb_id[k]    <= req_id_i[w_port_sel[k]];
          r_wb_pc[k]    <= req_pc_i[w_port_sel[k]];
          r_wb_prd[k]   <= req_prd_i[w_port_sel[k]];
          r_wb_rdval[k] <= req_rdval_i[w_port_sel[k]];
        end
      end
    end
  end

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_conflicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_grants    <= '0;
      r_perf_conflicts <= '0;
    end else if (!flush_i) begin
      r_perf_grants <= r_perf_grants + 32'($countones(w_grant));
      if ($countones(req_valid_i) > NR_PORTS)
        r_perf_conflicts <= r_perf_conflicts + 32'd1;
    end
  end

  assign perf_grants_o    = r_perf_grants;
  assign perf_conflicts_o = r_perf_conflicts;
`endif

  assign req_ready_o  = w_grant;
  assign wb_valid_o   = r_wb_valid;
  assign wb_id_o      = r_wb_id;
  assign wb_pc_o      = r_wb_pc;
  assign wb_prd_o     = r_wb_prd;
  assign wb_rdval_o   = r_wb_rdval;
  assign dbg_rr_ptr_o = r_rr_ptr;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter (NR_REQ=4, NR_PORTS=2). The driver
//   applies one cycle of stimulus per step, checks ready and rr_ptr
//   immediately, and pushes the expected next-cycle writeback state into
//   exp_q. The monitor pops one record after every rising edge and
//   compares it against the wb_* outputs.
module tb_wb_port_arbiter;

  localparam int NR_REQ   = 4;
  localparam int NR_PORTS = 2;
  localparam int ID_W     = 8;
  localparam int PREG_W   = 6;
  localparam int XLEN     = 64;
  localparam int PL_W     = ID_W + PREG_W + XLEN + XLEN;
  localparam int REC_W    = 1 + NR_PORTS + NR_PORTS * PL_W;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             flush_i = 1'b0;
  logic [NR_REQ-1:0]                req_valid_i = '0;
  logic [NR_REQ-1:0]                req_ready_o;
  logic [NR_REQ-1:0][ID_W-1:0]      req_id_i;
  logic [NR_REQ-1:0][XLEN-1:0]      req_pc_i;
  logic [NR_REQ-1:0][PREG_W-1:0]    req_prd_i;
  logic [NR_REQ-1:0][XLEN-1:0]      req_rdval_i;
  logic [NR_PORTS-1:0]              wb_valid_o;
  logic [NR_PORTS-1:0][ID_W-1:0]    wb_id_o;
  logic [NR_PORTS-1:0][XLEN-1:0]    wb_pc_o;
  logic [NR_PORTS-1:0][PREG_W-1:0]  wb_prd_o;
  logic [NR_PORTS-1:0][XLEN-1:0]    wb_rdval_o;
  logic [1:0]                       dbg_rr_ptr_o;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0]                      perf_grants_o;
  logic [31:0]                      perf_conflicts_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [REC_W-1:0] exp_q[$];

  wb_port_arbiter #(
    .NR_REQ(NR_REQ), .NR_PORTS(NR_PORTS), .ID_W(ID_W),
    .PREG_W(PREG_W), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_pc_i(req_pc_i),
    .req_prd_i(req_prd_i), .req_rdval_i(req_rdval_i),
    .wb_valid_o(wb_valid_o), .wb_id_o(wb_id_o), .wb_pc_o(wb_pc_o),
    .wb_prd_o(wb_prd_o), .wb_rdval_o(wb_rdval_o),
`ifdef WB_PORT_ARBITER_PERF_EN
    .perf_grants_o(perf_grants_o), .perf_conflicts_o(perf_conflicts_o),
`endif
    .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [PL_W-1:0] act,
                       input logic [PL_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PL_W-1:0] req_payload(input int r);
    return {req_id_i[r], req_prd_i[r], req_pc_i[r], req_rdval_i[r]};
  endfunction

  function automatic logic [PL_W-1:0] wb_payload(input int k);
    return {wb_id_o[k], wb_prd_o[k], wb_pc_o[k], wb_rdval_o[k]};
  endfunction

  // ---------------- driver ----------------
  // s0/s1: requester expected on port 0/1 next cycle, -1 for none.
  // zero: next cycle all payloads must read 0 (post-reset).
  task automatic step(input logic [3:0] v, input logic fl, input logic r,
                      input logic [3:0] exp_rdy, input int s0, input int s1,
                      input logic [1:0] exp_ptr, input logic zero);
    logic [REC_W-1:0] rec;
    logic [PL_W-1:0] p0, p1;
    logic [1:0] wbv;
    @(negedge clk);
    req_valid_i = v;
    flush_i     = fl;
    rst         = r;
    #1;
    check("ready", PL_W'(req_ready_o), PL_W'(exp_rdy));
    check("rr_ptr", PL_W'(dbg_rr_ptr_o), PL_W'(exp_ptr));
    wbv = {s1 >= 0, s0 >= 0};
    p0  = (s0 >= 0) ? req_payload(s0) : '0;
    p1  = (s1 >= 0) ? req_payload(s1) : '0;
    rec = {zero, wbv, p1, p0};
    exp_q.push_back(rec);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [REC_W-1:0] rec;
    logic [1:0] ev;
    #2;
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      ev  = rec[REC_W-2 -: 2];
      check("wb_valid", PL_W'(wb_valid_o), PL_W'(ev));
      if (ev[0]) check("wb_port0", wb_payload(0), rec[PL_W-1:0]);
      if (ev[1]) check("wb_port1", wb_payload(1), rec[2*PL_W-1:PL_W]);
      if (rec[REC_W-1]) begin
        check("wb_port0_zero", wb_payload(0), '0);
        check("wb_port1_zero", wb_payload(1), '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < NR_REQ; r++) begin
      req_id_i[r]    = 8'(8'hA0 + r);
      req_pc_i[r]    = 64'h1000 + 64'(r * 4);
      req_prd_i[r]   = 6'(8 + r);
      req_rdval_i[r] = 64'(r + 1) * 64'h0101_0101_0101_0101;
    end
    req_valid_i = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, with all requesters valid while rst is high.
    check("rst_ready", PL_W'(req_ready_o), '0);
    check("rst_wb_valid", PL_W'(wb_valid_o), '0);
    check("rst_port0", wb_payload(0), '0);
    check("rst_port1", wb_payload(1), '0);
    check("rst_ptr", PL_W'(dbg_rr_ptr_o), '0);

    //    valid    fl    rst   ready    s0  s1  ptr   zero
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, 2'd0, 1'b0);
    // All four valid: pairs alternate.
    step(4'b1111, 1'b0, 1'b0, 4'b0011,  0,  1, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 4'b1100,  2,  3, 2'd2, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 4'b0011,  0,  1, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 4'b1100,  2,  3, 2'd2, 1'b0);
    // Single r2 moves the pointer to 3.
    step(4'b0100, 1'b0, 1'b0, 4'b0100,  2, -1, 2'd0, 1'b0);
    // Wrap: r3 before r0.
    step(4'b1001, 1'b0, 1'b0, 4'b1001,  3,  0, 2'd3, 1'b0);
    req_rdval_i[2] = 64'h0000_0000_DEAD_BEEF;
    req_prd_i[2]   = 6'd5;
    step(4'b0100, 1'b0, 1'b0, 4'b0100,  2, -1, 2'd1, 1'b0);
    // Flush: no grants, pointer holds at 3.
    step(4'b1111, 1'b1, 1'b0, 4'b0000, -1, -1, 2'd3, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 4'b1001,  3,  0, 2'd3, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 4'b0110,  1,  2, 2'd1, 1'b0);
    // Reset together with flush mid-stream.
    step(4'b1111, 1'b1, 1'b1, 4'b0000, -1, -1, 2'd3, 1'b1);
    step(4'b1010, 1'b0, 1'b0, 4'b1010,  1,  3, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 4'b0001,  0, -1, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, 2'd1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1, 2'd1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end

`ifdef WB_PORT_ARBITER_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("perf_grants_rst", PL_W'(perf_grants_o), '0);
    check("perf_conflicts_rst", PL_W'(perf_conflicts_o), '0);
    req_valid_i = 4'b0111;
    repeat (10) @(negedge clk);
    check("perf_grants_10", PL_W'(perf_grants_o), PL_W'(32'd20));
    check("perf_conflicts_10", PL_W'(perf_conflicts_o), PL_W'(32'd10));
    req_valid_i = 4'b0001;
    repeat (5) @(negedge clk);
    check("perf_grants_15", PL_W'(perf_grants_o), PL_W'(32'd25));
    check("perf_conflicts_15", PL_W'(perf_conflicts_o), PL_W'(32'd10));
    req_valid_i = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
